// File: rtl/mult_seq_if.sv
// Operand/result bundle between the register-read stage, the multiplier and the ALU.
interface mult_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sinal;
  logic [WIDTH-1:0] operando1;
  logic [WIDTH-1:0] operando2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mulH;
  logic [WIDTH-1:0] mulL;

  modport master (
    output start, sinal, operando1, operando2,
    input  busy, done, mulH, mulL
  );

  modport slave (
    input  start, sinal, operando1, operando2,
    output busy, done, mulH, mulL
  );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, sign handled by
// multiplying magnitudes and negating the finished product.
//
// state | meaning
// IDLE  | waiting for start; product registers hold the last result
// CALC  | WIDTH add/shift iterations, LSB of the multiplier first
// FIN   | apply sign, write mulH/mulL, pulse done
module mult_seq #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      reset,
  mult_seq_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mulh_q, mulh_d;
  logic [WIDTH-1:0] mull_q, mull_d;

  logic             sign_mode;
  logic [WIDTH-1:0] mag1, mag2;
  logic [PW-1:0]    product;

  // Operand magnitudes at capture time and the signed final product.
  // The most-negative operand maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    sign_mode = bus.sinal;
    mag1      = (sign_mode && bus.operando1[WIDTH-1]) ? (~bus.operando1 + 1'b1) : bus.operando1;
    mag2      = (sign_mode && bus.operando2[WIDTH-1]) ? (~bus.operando2 + 1'b1) : bus.operando2;
    product   = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  // Next-state and datapath update; the multiplicand shifts left and the
  // multiplier shifts right so the current bit is always mplier_q[0].
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mulh_d   = mulh_q;
    mull_d   = mull_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          neg_d    = sign_mode & (bus.operando1[WIDTH-1] ^ bus.operando2[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        mulh_d  = product[PW-1:WIDTH];
        mull_d  = product[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; a reset mid-operation discards everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mulh_q   <= '0;
      mull_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mulh_q   <= mulh_d;
      mull_q   <= mull_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.mulH = mulh_q;
  assign bus.mulL = mull_q;
endmodule
